// File: rtl/rc_acc_seq_16b_if.sv
// Stream, adder and result signals of the rc_acc_seq_16b operand sequencer.
// The slave modport is the sequencer; master is whatever feeds it and hosts the adder.
interface rc_acc_seq_16b_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/rc_acc_seq_16b.sv
// Burst operand sequencer wrapped around an external combinational ripple-carry adder.
// Define RC_ACC_SATURATE_EN to make the accumulator saturate on carry instead of wrapping.
module rc_acc_seq_16b #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 8
) (
    input logic                clk,
    input logic                rst,
    rc_acc_seq_16b_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             op_pend_q, op_pend_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_next;

`ifdef RC_ACC_SATURATE_EN
    assign acc_next = bus.add_cout ? {WIDTH{1'b1}} : bus.add_s;
`else
    assign acc_next = bus.add_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            op_q      <= '0;
            op_pend_q <= 1'b0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            op_pend_q <= op_pend_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        op_pend_d = op_pend_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    op_pend_d = 1'b0;
                    rem_d     = bus.len;
                    state_d   = (bus.len != '0) ? StAcc : StDone;
                end
            end
            StAcc: begin
                // The operand sits on add_b for a full cycle before its sum is captured.
                if (op_pend_q) begin
                    acc_d     = acc_next;
                    ovf_d     = ovf_q | bus.add_cout;
                    op_pend_d = 1'b0;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = StDone;
                end else if (bus.in_valid) begin
                    op_d      = bus.in_data;
                    op_pend_d = 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StAcc) && !op_pend_q;
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.add_a     = acc_q;
    assign bus.add_b     = op_q;
    assign bus.add_cin   = 1'b0;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rc_acc_seq_16b.sv
// Directed bench for rc_acc_seq_16b with a behavioural rc_16b adder and a result scoreboard.
module tb_rc_acc_seq_16b;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] ops_buf [8];

    rc_acc_seq_16b_if #(.WIDTH(16), .LEN_W(8)) bus ();

    rc_acc_seq_16b #(.WIDTH(16), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ripple-carry adder
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_burst(input int n);
        exp_t        r;
        logic [16:0] t;
        r.sum = 16'h0;
        r.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = {1'b0, r.sum} + {1'b0, ops_buf[i]};
`ifdef RC_ACC_SATURATE_EN
            r.sum = t[16] ? 16'hFFFF : t[15:0];
`else
            r.sum = t[15:0];
`endif
            r.ovf = r.ovf | t[16];
        end
        return r;
    endfunction

    task automatic start_burst(input int n);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        tick();
        bus.start = 1'b0;
        bus.len   = 8'd0;
    endtask

    task automatic send_op(input logic [15:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_out_sum"},   {16'd0, bus.out_sum},   32'd0);
        check({tag, "_out_ovf"},   {31'd0, bus.out_ovf},   32'd0);
        check({tag, "_add_a"},     {16'd0, bus.add_a},     32'd0);
        check({tag, "_add_b"},     {16'd0, bus.add_b},     32'd0);
        check({tag, "_add_cin"},   {31'd0, bus.add_cin},   32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    endtask

    task automatic collect(input string tag, input int hold, input bit start_in_done);
        int   n = 0;
        exp_t e;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < hold; k++) begin
            check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_sum"},   {16'd0, bus.out_sum},   {16'd0, e.sum});
            if (start_in_done && k == 1) begin
                bus.start = 1'b1;
                bus.len   = 8'd3;
            end
            tick();
            bus.start = 1'b0;
            bus.len   = 8'd0;
        end
        check({tag, "_sum"}, {16'd0, bus.out_sum}, {16'd0, e.sum});
        check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, e.ovf});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_fall"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_busy_fall"},  {31'd0, bus.busy},      32'd0);
        tick();
        check({tag, "_stay_idle"},  {31'd0, bus.busy},      32'd0);
    endtask

    task automatic run_burst(input string tag, input int n, input int gap, input int hold,
                             input bit start_in_done);
        sb.push_back(model_burst(n));
        start_burst(n);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            send_op(ops_buf[i]);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
        collect(tag, hold, start_in_done);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_zero("reset");

        ops_buf[0] = 16'h0001; ops_buf[1] = 16'h0002; ops_buf[2] = 16'h0003;
        run_burst("basic", 3, 0, 0, 1'b0);

        ops_buf[0] = 16'hFFFF; ops_buf[1] = 16'h0002;
        run_burst("carry", 2, 0, 0, 1'b0);

        sb.push_back(model_burst(0));
        start_burst(0);
        check("zlen_valid_next", {31'd0, bus.out_valid}, 32'd1);
        check("zlen_in_ready",   {31'd0, bus.in_ready},  32'd0);
        collect("zlen", 0, 1'b0);

        for (int i = 0; i < 4; i++) ops_buf[i] = 16'h1000;
        run_burst("stall", 4, 3, 5, 1'b1);

        ops_buf[0] = 16'h00FF; ops_buf[1] = 16'h0001;
        sb.push_back(model_burst(2));
        start_burst(2);
        send_op(16'h00FF);
        check("adder_a0",       {16'd0, bus.add_a},     32'h0000);
        check("adder_b0",       {16'd0, bus.add_b},     32'h00FF);
        check("adder_cin",      {31'd0, bus.add_cin},   32'd0);
        check("adder_in_ready0", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("adder_a1",       {16'd0, bus.add_a},     32'h00FF);
        check("adder_in_ready1", {31'd0, bus.in_ready}, 32'd1);
        send_op(16'h0001);
        collect("adder", 0, 1'b0);

        start_burst(4);
        send_op(16'h0111);
        send_op(16'h0222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");

        ops_buf[0] = 16'h0005;
        run_burst("after_rst", 1, 0, 0, 1'b0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
